// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks EX/MEM/WB producers and decides the forwarding selects, load-use stalls and branch flushes.
module hazard_fwd_ctrl #(
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] id_rd,
  input  logic [2:0]      id_op_cat,
  input  logic            id_use_rs,
  input  logic            id_use_rt,
  input  logic            id_use_imm,
  input  logic            id_wr,
  input  logic            ex_branch,
  output logic [1:0]      sels,
  output logic [1:0]      selt,
  output logic [1:0]      seld,
  output logic            stall,
  output logic            flush,
  output logic            ex_v,
  output logic            mem_v,
  output logic            wb_v
);

  localparam logic [2:0] CAT_BR1 = 3'd1, CAT_BR2 = 3'd2, CAT_LD = 3'd3, CAT_ST = 3'd4;

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] dst;
    logic            wr;
  } slot_t;

  slot_t ex_q, mem_q, id_rec;
  logic  ex_ld, ex_br, wb_q;

  // The EX producer is youngest; a load in EX cannot forward yet, so fall back to MEM.
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] x, input slot_t ex,
                                         input logic ex_is_ld, input slot_t mem);
    logic hit_ex, hit_mem;
    hit_ex  = ex.v & ex.wr & (ex.dst == x);
    hit_mem = mem.v & mem.wr & (mem.dst == x);
    if (hit_ex && !ex_is_ld) return 2'd3;
    else if (hit_mem)        return 2'd2;
    else                     return 2'd1;
  endfunction

  logic       is_st, rt_used, ld_hit, adv;
  logic [1:0] n_sels, n_selt, n_seld;

  always_comb begin
    is_st   = (id_op_cat == CAT_ST);
    rt_used = id_use_rt | is_st;
    ld_hit  = ex_q.v & ex_ld & ex_q.wr &
              ((id_use_rs & (ex_q.dst == id_rs)) | (rt_used & (ex_q.dst == id_rt)));
    flush   = rst_n & ex_branch & ex_q.v & ex_br;
    stall   = rst_n & id_valid & ld_hit & ~flush;
    adv     = id_valid & ~stall & ~flush;

    id_rec.v   = 1'b1;
    id_rec.dst = id_rd;
    id_rec.wr  = id_wr & (id_rd != '0);

    n_sels = id_use_rs  ? fwd_sel(id_rs, ex_q, ex_ld, mem_q) : 2'd0;
    n_selt = id_use_imm ? 2'd0 : fwd_sel(id_rt, ex_q, ex_ld, mem_q);
    n_seld = is_st      ? fwd_sel(id_rt, ex_q, ex_ld, mem_q) : 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      ex_ld <= 1'b0;
      ex_br <= 1'b0;
      mem_q <= '0;
      wb_q  <= 1'b0;
      sels  <= 2'd0;
      selt  <= 2'd0;
      seld  <= 2'd1;
    end else begin
      wb_q  <= mem_q.v;
      mem_q <= ex_q;
      if (adv) begin
        ex_q  <= id_rec;
        ex_ld <= (id_op_cat == CAT_LD);
        ex_br <= (id_op_cat == CAT_BR1) || (id_op_cat == CAT_BR2);
        sels  <= n_sels;
        selt  <= n_selt;
        seld  <= n_seld;
      end else begin
        ex_q  <= '0;
        ex_ld <= 1'b0;
        ex_br <= 1'b0;
        sels  <= 2'd0;
        selt  <= 2'd0;
        seld  <= 2'd1;
      end
    end
  end

  assign ex_v  = ex_q.v;
  assign mem_v = mem_q.v;
  assign wb_v  = wb_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Bench for hazard_fwd_ctrl: directed vector table for the named scenarios, then
// randomized traffic checked against an in-flight instruction queue model.
module tb_hazard_fwd_ctrl;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst_n, id_valid, id_use_rs, id_use_rt, id_use_imm, id_wr, ex_branch;
  logic [REGW-1:0] id_rs, id_rt, id_rd;
  logic [2:0]      id_op_cat;
  logic [1:0]      sels, selt, seld;
  logic            stall, flush, ex_v, mem_v, wb_v;

  hazard_fwd_ctrl #(.REGW(REGW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_op_cat(id_op_cat), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_imm(id_use_imm),
    .id_wr(id_wr), .ex_branch(ex_branch), .sels(sels), .selt(selt), .seld(seld),
    .stall(stall), .flush(flush), .ex_v(ex_v), .mem_v(mem_v), .wb_v(wb_v)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input bit r, input bit v, input int rs, input int rt, input int rd, input int cat,
                       input bit urs, input bit urt, input bit imm, input bit wr, input bit br);
    rst_n = r; id_valid = v; id_rs = REGW'(rs); id_rt = REGW'(rt); id_rd = REGW'(rd);
    id_op_cat = 3'(cat); id_use_rs = urs; id_use_rt = urt; id_use_imm = imm; id_wr = wr; ex_branch = br;
  endtask

  typedef struct {
    bit r, v; int rs, rt, rd, cat; bit urs, urt, imm, wr, br;
    bit e_stall, e_flush; int e_sels, e_selt, e_seld; bit e_exv, e_mv, e_wv;
  } vec_t;

  function automatic vec_t mk(bit r, bit v, int rs, int rt, int rd, int cat, bit urs, bit urt, bit imm,
                              bit wr, bit br, bit st, bit fl, int ss, int st2, int sd, bit ev, bit mv, bit wv);
    vec_t x;
    x.r = r; x.v = v; x.rs = rs; x.rt = rt; x.rd = rd; x.cat = cat; x.urs = urs; x.urt = urt;
    x.imm = imm; x.wr = wr; x.br = br; x.e_stall = st; x.e_flush = fl; x.e_sels = ss;
    x.e_selt = st2; x.e_seld = sd; x.e_exv = ev; x.e_mv = mv; x.e_wv = wv;
    return x;
  endfunction

  // Reference model: queue of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct { bit v; int dst; bit wr, ld, br; } ent_t;
  ent_t q[$];

  function automatic int src_sel(int x);
    for (int age = 0; age < 2; age++) begin
      if (q[age].v && q[age].wr && q[age].dst == x) begin
        if (age == 0 && q[age].ld) continue;
        return (age == 0) ? 3 : 2;
      end
    end
    return 1;
  endfunction

  function automatic void model_reset();
    ent_t b = '{0, 0, 0, 0, 0};
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(b);
  endfunction

  vec_t tbl[20];

  initial begin
    tbl[0]  = mk(1,1,1,2,3,0,1,1,0,1,0, 0,0,1,1,1,1,0,0);
    tbl[1]  = mk(1,1,3,5,4,0,1,1,0,1,0, 0,0,3,1,1,1,1,0);
    tbl[2]  = mk(1,1,1,2,3,0,1,1,0,1,0, 0,0,1,1,1,1,1,1);
    tbl[3]  = mk(1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0,1,1);
    tbl[4]  = mk(1,1,5,3,6,0,1,1,0,1,0, 0,0,1,2,1,1,0,1);
    tbl[5]  = mk(1,1,1,0,7,3,1,0,1,1,0, 0,0,1,0,1,1,1,0);
    tbl[6]  = mk(1,1,7,7,8,0,1,1,0,1,0, 1,0,0,0,1,0,1,1);
    tbl[7]  = mk(1,1,7,7,8,0,1,1,0,1,0, 0,0,2,2,1,1,0,1);
    tbl[8]  = mk(1,1,1,2,0,1,1,1,0,0,0, 0,0,1,1,1,1,1,0);
    tbl[9]  = mk(1,1,8,1,9,0,1,1,0,1,1, 0,1,0,0,1,0,1,1);
    tbl[10] = mk(1,1,1,0,7,3,1,0,1,1,0, 0,0,1,0,1,1,0,1);
    tbl[11] = mk(1,1,7,2,8,0,1,1,0,1,1, 1,0,0,0,1,0,1,0);
    tbl[12] = mk(1,1,7,2,8,0,1,1,0,1,0, 0,0,2,1,1,1,0,1);
    tbl[13] = mk(1,1,1,2,0,0,1,1,0,1,0, 0,0,1,1,1,1,1,0);
    tbl[14] = mk(1,1,0,0,5,0,1,1,0,1,0, 0,0,1,1,1,1,1,1);
    tbl[15] = mk(1,1,1,2,9,0,1,1,0,1,0, 0,0,1,1,1,1,1,1);
    tbl[16] = mk(1,1,1,9,0,4,1,0,1,0,0, 0,0,1,0,3,1,1,1);
    tbl[17] = mk(1,1,1,0,7,3,1,0,1,1,0, 0,0,1,0,1,1,1,1);
    tbl[18] = mk(0,1,7,7,8,0,1,1,0,1,0, 0,0,0,0,1,0,0,0);
    tbl[19] = mk(1,1,7,7,8,0,1,1,0,1,0, 0,0,1,1,1,1,0,0);

    // Reset with a load-use-looking ID instruction: stall/flush must stay low.
    drive(0,1,1,1,1,0,1,1,0,1,1);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sels", sels, 0); chk("rst_selt", selt, 0); chk("rst_seld", seld, 1);
    chk("rst_exv", ex_v, 0);  chk("rst_memv", mem_v, 0); chk("rst_wbv", wb_v, 0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].cat,
            tbl[i].urs, tbl[i].urt, tbl[i].imm, tbl[i].wr, tbl[i].br);
      #1;
      chk($sformatf("v%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("v%0d_flush", i), flush, tbl[i].e_flush);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_sels", i), sels, tbl[i].e_sels);
      chk($sformatf("v%0d_selt", i), selt, tbl[i].e_selt);
      chk($sformatf("v%0d_seld", i), seld, tbl[i].e_seld);
      chk($sformatf("v%0d_exv", i), ex_v, tbl[i].e_exv);
      chk($sformatf("v%0d_memv", i), mem_v, tbl[i].e_mv);
      chk($sformatf("v%0d_wbv", i), wb_v, tbl[i].e_wv);
    end

    // Randomized traffic over a small register set so hazards are frequent.
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit r, v, urs, urt, imm, wr, br, is_st, e_flush, e_stall, acc;
      int rs, rt, rd, cat, e_sels, e_selt, e_seld;
      ent_t ne;
      r   = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      v   = $urandom_range(0, 5) != 0;
      rs  = $urandom_range(0, 3); rt = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      cat = $urandom_range(0, 7);
      urs = $urandom_range(0, 1); urt = $urandom_range(0, 1); imm = $urandom_range(0, 1);
      wr  = $urandom_range(0, 1); br  = $urandom_range(0, 1);
      drive(r, v, rs, rt, rd, cat, urs, urt, imm, wr, br);

      is_st   = (cat == 4);
      e_flush = r && br && q[0].v && q[0].br;
      e_stall = r && !e_flush && v && q[0].v && q[0].ld && q[0].wr &&
                ((urs && q[0].dst == rs) || ((urt || is_st) && q[0].dst == rt));
      acc     = v && !e_stall && !e_flush;
      e_sels  = (acc && urs) ? src_sel(rs) : 0;
      e_selt  = (acc && !imm) ? src_sel(rt) : 0;
      e_seld  = (acc && is_st) ? src_sel(rt) : 1;
      #1;
      chk("rnd_stall", stall, e_stall);
      chk("rnd_flush", flush, e_flush);
      @(posedge clk);
      if (!r) begin
        model_reset();
        e_sels = 0; e_selt = 0; e_seld = 1;
      end else begin
        ne = '{0, 0, 0, 0, 0};
        if (acc) ne = '{1, rd, wr && rd != 0, cat == 3, cat == 1 || cat == 2};
        q.push_front(ne);
        void'(q.pop_back());
      end
      #1;
      chk("rnd_sels", sels, e_sels);
      chk("rnd_selt", selt, e_selt);
      chk("rnd_seld", seld, e_seld);
      chk("rnd_exv", ex_v, q[0].v);
      chk("rnd_memv", mem_v, q[1].v);
      chk("rnd_wbv", wb_v, q[2].v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
